// File: rtl/rand_disp_pkg.sv
// Shared definitions for the random-sample display block.
//   - deb_state_e : key debounce FSM states
//   - SEG_BLANK   : all segments off (active-low)
//   - SEG_TABLE   : hex digit -> active-low 7-segment pattern, bit0=a .. bit6=g
package rand_disp_pkg;

    typedef enum logic [1:0] {
        REL   = 2'd0,  // key released, idle
        PWAIT = 2'd1,  // key seen low, qualifying the press
        PRS   = 2'd2,  // press accepted
        RWAIT = 2'd3   // key seen high, qualifying the release
    } deb_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_hex.sv
// Combinational 4-bit hex digit to active-low 7-segment decoder.
// Ports:
//   nib : hex digit to display
//   seg : segment drive, active-low, bit0=a .. bit6=g
module seg7_hex
    import rand_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nib];
    end

endmodule

// File: rtl/rand_sample_disp.sv
// Captures the LFSR value on each debounced key press and shows it in hex on two
// 7-segment digits; counts captures.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   key_n       : raw bouncy pushbutton, active-low, asynchronous
//   rand_num    : LFSR value, sampled at the capture edge
//   sample      : last captured value
//   sample_vld  : one-cycle pulse after each capture
//   smp_cnt     : capture count, wraps modulo 2**CNT_W
//   hex0, hex1  : low / high nibble of sample (blank until the first capture)
//   hex2        : capture-count digit
// Build option: SAMPLE_CNT_DISP_EN drives hex2 from smp_cnt[3:0]; otherwise hex2 is blank.
module rand_sample_disp
    import rand_disp_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 20,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_n,
    input  logic [7:0]       rand_num,
    output logic [7:0]       sample,
    output logic             sample_vld,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2
);

    localparam int unsigned DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // Key synchroniser; resets to the released level.
    logic [1:0] sync_q;
    logic       key_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n};
        end
    end

    assign key_s = sync_q[1];

    // Debounce FSM
    deb_state_e       state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             capture;

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        capture   = 1'b0;
        unique case (state_q)
            REL: begin
                if (!key_s) state_d = PWAIT;
            end
            PWAIT: begin
                if (key_s) begin
                    state_d = REL;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = PRS;
                    capture = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRS: begin
                if (key_s) state_d = RWAIT;
            end
            RWAIT: begin
                if (!key_s) begin
                    state_d = PRS;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = REL;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = REL;
        endcase
        // Every qualification window starts from zero.
        if (state_d != state_q) deb_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= REL;
            deb_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Capture registers
    logic [7:0]       sample_q;
    logic             vld_q;
    logic [CNT_W-1:0] cnt_q;
    logic             shown_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            vld_q    <= 1'b0;
            cnt_q    <= '0;
            shown_q  <= 1'b0;
        end else begin
            vld_q <= capture;
            if (capture) begin
                sample_q <= rand_num;
                cnt_q    <= cnt_q + 1'b1;
                shown_q  <= 1'b1;
            end
        end
    end

    assign sample     = sample_q;
    assign sample_vld = vld_q;
    assign smp_cnt    = cnt_q;

    // Sample display, registered one cycle behind the capture registers
    logic [6:0] seg_lo, seg_hi;
    logic [6:0] hex0_q, hex1_q;

    seg7_hex u_seg_lo (
        .nib (sample_q[3:0]),
        .seg (seg_lo)
    );

    seg7_hex u_seg_hi (
        .nib (sample_q[7:4]),
        .seg (seg_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex0_q <= SEG_BLANK;
            hex1_q <= SEG_BLANK;
        end else begin
            hex0_q <= shown_q ? seg_lo : SEG_BLANK;
            hex1_q <= shown_q ? seg_hi : SEG_BLANK;
        end
    end

    assign hex0 = hex0_q;
    assign hex1 = hex1_q;

`ifdef SAMPLE_CNT_DISP_EN
    // Count digit: low nibble of the counter, zero-extended for narrow counters.
    logic [3:0] cnt_nib;
    logic [6:0] seg_cnt;
    logic [6:0] hex2_q;

    assign cnt_nib = 4'(cnt_q);

    seg7_hex u_seg_cnt (
        .nib (cnt_nib),
        .seg (seg_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex2_q <= SEG_TABLE[0];
        end else begin
            hex2_q <= seg_cnt;
        end
    end

    assign hex2 = hex2_q;
`else
    assign hex2 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_rand_sample_disp.sv
// Self-checking bench for rand_sample_disp (DEB_CYCLES=4, CNT_W=4).
module tb_rand_sample_disp;

    localparam int unsigned DEB   = 4;
    localparam int unsigned CNT_W = 4;

`ifdef SAMPLE_CNT_DISP_EN
    localparam bit CNT_DISP = 1'b1;
`else
    localparam bit CNT_DISP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             key_n = 1'b1;
    logic [7:0]       rand_num = 8'h00;
    logic [7:0]       sample;
    logic             sample_vld;
    logic [CNT_W-1:0] smp_cnt;
    logic [6:0]       hex0, hex1, hex2;

    always #5 clk = ~clk;

    rand_sample_disp #(
        .DEB_CYCLES (DEB),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .rand_num   (rand_num),
        .sample     (sample),
        .sample_vld (sample_vld),
        .smp_cnt    (smp_cnt),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2)
    );

    int n_cmp = 0;
    int n_err = 0;
    int vld_seen = 0;
    int first_vld = -1;
    int cyc_idx = 0;

    // Reference model: key level seen two clocks late, a press/release is accepted once
    // the new level has been seen on DEB+1 consecutive cycles.
    logic [1:0] m_sync;
    logic       m_pressed;
    int         m_run;
    logic [7:0] m_sample;
    logic       m_vld;
    logic [3:0] m_cnt;
    logic       m_shown;
    logic [6:0] m_hex0, m_hex1, m_hex2;

    function automatic logic [6:0] tb_seg(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic model_reset();
        m_sync    = 2'b11;
        m_pressed = 1'b0;
        m_run     = 0;
        m_sample  = 8'h00;
        m_vld     = 1'b0;
        m_cnt     = 4'h0;
        m_shown   = 1'b0;
        m_hex0    = 7'h7F;
        m_hex1    = 7'h7F;
        m_hex2    = CNT_DISP ? 7'h40 : 7'h7F;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input logic kn, input logic [7:0] rn);
        logic [6:0] n_hex0, n_hex1, n_hex2;
        logic       cap;
        n_hex0 = m_shown ? tb_seg(m_sample[3:0]) : 7'h7F;
        n_hex1 = m_shown ? tb_seg(m_sample[7:4]) : 7'h7F;
        n_hex2 = CNT_DISP ? tb_seg(m_cnt) : 7'h7F;
        cap = 1'b0;
        // Released: waiting for low (0). Pressed: waiting for high (1).
        if (m_sync[1] == m_pressed) begin
            m_run++;
            if (m_run == int'(DEB) + 1) begin
                m_pressed = ~m_pressed;
                m_run     = 0;
                cap       = m_pressed;
            end
        end else begin
            m_run = 0;
        end
        m_vld = cap;
        if (cap) begin
            m_sample = rn;
            m_cnt    = m_cnt + 4'd1;
            m_shown  = 1'b1;
        end
        m_sync = {m_sync[0], kn};
        m_hex0 = n_hex0;
        m_hex1 = n_hex1;
        m_hex2 = n_hex2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("sample",     32'(sample),     32'(m_sample));
        check("sample_vld", 32'(sample_vld), 32'(m_vld));
        check("smp_cnt",    32'(smp_cnt),    32'(m_cnt));
        check("hex0",       32'(hex0),       32'(m_hex0));
        check("hex1",       32'(hex1),       32'(m_hex1));
        check("hex2",       32'(hex2),       32'(m_hex2));
    endtask

    // Drive for n cycles; entered and left 1 time unit after a rising edge.
    task automatic run(input logic kn, input logic [7:0] rn, input int n);
        for (int i = 0; i < n; i++) begin
            key_n    = kn;
            rand_num = rn;
            @(negedge clk);
            check_outputs();
            if (sample_vld) begin
                vld_seen++;
                if (first_vld < 0) first_vld = cyc_idx;
            end
            cyc_idx++;
            if (rst_n) model_step(kn, rn);
            else model_reset();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [7:0] v);
        run(1'b0, v, 10);
        run(1'b1, v, 10);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        run(1'b1, 8'h00, 3);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] val;
        logic [6:0] h1;
        logic [6:0] h0;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [7:0] rn;
        vecs[0] = '{8'hA5, 7'h08, 7'h12};
        vecs[1] = '{8'h3C, 7'h30, 7'h46};
        vecs[2] = '{8'hF0, 7'h0E, 7'h40};
        vecs[3] = '{8'h00, 7'h40, 7'h40};
        vecs[4] = '{8'h9B, 7'h10, 7'h03};
        vecs[5] = '{8'h6D, 7'h02, 7'h21};
        vecs[6] = '{8'h87, 7'h00, 7'h78};
        vecs[7] = '{8'hE1, 7'h06, 7'h79};
        vecs[8] = '{8'h2F, 7'h24, 7'h0E};
        vecs[9] = '{8'h54, 7'h12, 7'h19};

        model_reset();
        @(posedge clk);
        #1;

        // Reset and idle
        do_reset();
        check("rst_sample", 32'(sample), 32'h0);
        check("rst_hex0", 32'(hex0), 32'h7F);
        check("rst_hex2", 32'(hex2), CNT_DISP ? 32'h40 : 32'h7F);
        vld_seen = 0;
        for (int i = 0; i < 50; i++) run(1'b1, 8'($urandom), 1);
        check("idle_no_vld", 32'(vld_seen), 32'd0);
        check("idle_hex1", 32'(hex1), 32'h7F);

        // Clean press with A5: pulse 7 cycles after the fall, display one cycle later
        vld_seen  = 0;
        first_vld = -1;
        cyc_idx   = 0;
        run(1'b0, 8'hA5, 9);
        check("clean_latency", 32'(first_vld), 32'd7);
        check("clean_sample", 32'(sample), 32'hA5);
        check("clean_cnt", 32'(smp_cnt), 32'd1);
        check("clean_hex1", 32'(hex1), 32'h08);
        check("clean_hex0", 32'(hex0), 32'h12);
        run(1'b0, 8'hA5, 11);
        run(1'b1, 8'hA5, 12);
        check("clean_one_pulse", 32'(vld_seen), 32'd1);

        // Bounce with rand_num stepping every cycle
        vld_seen = 0;
        rn = 8'($urandom);
        for (int i = 0; i < 3; i++) begin run(1'b0, rn, 1); rn++; end
        run(1'b1, rn, 1); rn++;
        for (int i = 0; i < 3; i++) begin run(1'b0, rn, 1); rn++; end
        run(1'b1, rn, 1); rn++;
        for (int i = 0; i < 10; i++) begin run(1'b0, rn, 1); rn++; end
        for (int i = 0; i < 12; i++) begin run(1'b1, rn, 1); rn++; end
        check("bounce_one_pulse", 32'(vld_seen), 32'd1);

        // Long hold, bouncy release, then a second press
        do_reset();
        vld_seen = 0;
        rn = 8'($urandom);
        run(1'b0, rn, 100);
        run(1'b1, rn, 2);
        run(1'b0, rn, 2);
        run(1'b1, rn, 2);
        run(1'b0, rn, 2);
        run(1'b1, rn, 15);
        check("hold_one_pulse", 32'(vld_seen), 32'd1);
        press(8'($urandom));
        check("second_press_cnt", 32'(smp_cnt), 32'd2);

        // Segment table over all 16 digits
        foreach (vecs[i]) begin
            press(vecs[i].val);
            check("tbl_sample", 32'(sample), 32'(vecs[i].val));
            check("tbl_hex1", 32'(hex1), 32'(vecs[i].h1));
            check("tbl_hex0", 32'(hex0), 32'(vecs[i].h0));
        end

        // Counter wrap
        do_reset();
        for (int i = 0; i < 15; i++) press(8'($urandom));
        check("wrap_cnt15", 32'(smp_cnt), 32'hF);
        press(8'($urandom));
        check("wrap_cnt0", 32'(smp_cnt), 32'h0);
        check("wrap_hex2", 32'(hex2), CNT_DISP ? 32'h40 : 32'h7F);

        // Reset two cycles into the press qualification
        do_reset();
        vld_seen = 0;
        run(1'b0, 8'h77, 5);
        rst_n = 1'b0;
        model_reset();
        run(1'b1, 8'h77, 3);
        check("midrst_no_vld", 32'(vld_seen), 32'd0);
        check("midrst_sample", 32'(sample), 32'h0);
        check("midrst_hex0", 32'(hex0), 32'h7F);
        rst_n = 1'b1;
        press(8'h3C);
        check("midrst_recover_vld", 32'(vld_seen), 32'd1);
        check("midrst_recover_smp", 32'(sample), 32'h3C);
        check("midrst_recover_cnt", 32'(smp_cnt), 32'd1);

        // Random key activity against the model
        for (int i = 0; i < 150; i++) begin
            logic kn;
            int   len;
            kn  = 1'($urandom);
            len = $urandom_range(1, 9);
            for (int j = 0; j < len; j++) run(kn, 8'($urandom), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
